tap_tick_timer: RTL and testbench
=================================

// Module: tap_tick_timer
// PURPOSE
//  Downstream consumer of the free-running 2-bit divider counter output q.
//  - Selects one counter bit (tap) and turns each of its rising edges into a
//    single-cycle clock-enable tick in the clk domain.
//  - Counts those ticks up to a programmable target and flags completion.
//  - Other logic uses it as a coarse interval timer without clocking any
//    flop from a divided clock.
// PARAMETERS
//  CNT_W    2   width of q_in (counter taps)
//  SEL_W    1   width of tap_sel; taps >= CNT_W never tick
//  TICKS_W  8   width of target and tick_count
// PORTS
//  clk         in   1        system clock, rising-edge
//  reset       in   1        synchronous, active-high
//  q_in        in   CNT_W    counter taps, synchronous to clk
//  tap_sel     in   SEL_W    index of the q_in bit to watch
//  start       in   1        1-cycle request to arm the timer
//  target      in   TICKS_W  tick count to reach; sampled when start is accepted
//  tick        out  1        1-cycle strobe per rising edge of the selected tap
//  busy        out  1        1 while in RUN
//  done        out  1        1 while in DONE
//  tick_count  out  TICKS_W  ticks counted since the last accepted start
// BEHAVIOUR
//  Reset: all outputs 0; internal q_prev 0; state IDLE; target_r 0.
//  Edge detect:
//   - q_prev <= q_in every cycle.
//   - edge = (tap_sel < CNT_W) & q_in[tap_sel] & ~q_prev[tap_sel].
//  tick:
//   - tick <= edge; one cycle of latency after the cycle in which the tap rises.
//   - Free-running in every state.
//   - A tap_sel change compares the new tap against its own previous sample,
//     so no false tick occurs unless that bit actually rose.
//   - The first cycle after reset can tick if the selected tap is already 1,
//     because q_prev is 0.
//  FSM (states IDLE, RUN, DONE):
//   - IDLE, start=1: target_r <= target, tick_count <= 0.
//     Goes to RUN, or to DONE if target == 0.
//   - RUN, tick=1: tick_count <= tick_count + 1.
//     If tick_count == target_r - 1, goes to DONE in the same update.
//     start is ignored in RUN.
//   - DONE: tick_count holds target_r.
//     start=1 re-arms exactly as from IDLE: count cleared, new target latched.
//  Outputs:
//   - busy = (state == RUN); done = (state == DONE). Both are registered state
//     decodes.
//   - busy and done rise in the cycle after start is accepted.
//   - done rises in the same cycle tick_count shows target_r.
//  Arithmetic:
//   - The count never exceeds target_r, so it never wraps.
//   - Max target is 2**TICKS_W - 1.
//  Simultaneous events:
//   - A tick in the same cycle start is accepted is not counted; counting begins
//     with ticks visible while busy = 1.
//   - reset overrides start and tick.
//  Reset mid-operation: the next cycle shows IDLE with all outputs 0. No partial
//  count is kept.
// TESTING (q_in driven by a free-running 2-bit up-counter on clk)
//  1. reset held 3 cycles while q_in counts
//     -> tick, busy, done = 0 and tick_count = 0 throughout.
//  2. tap_sel = 0 -> tick high 1 cycle in every 2, one cycle after q_in[0] rises.
//     tap_sel = 1 -> tick 1 cycle in every 4, one cycle after q_in goes 01 -> 10.
//  3. tap_sel = 1, start with target = 3
//     -> busy = 1 next cycle; tick_count steps 1, 2, 3, each on a tick.
//     -> done = 1 and busy = 0 with tick_count = 3, about 12 clk after start.
//  4. start with target = 0 -> done = 1 the next cycle, tick_count = 0, busy never 1.
//  5. start pulsed mid-RUN (target = 5 on the bus) -> ignored, original target
//     kept. Then start in DONE with target = 2 -> count clears to 0 and done = 1
//     at 2.
//  6. reset asserted in RUN with tick_count = 1
//     -> next cycle IDLE, all outputs 0; a later start behaves as in test 3.

Source files
------------

// File: rtl/tap_tick_timer_if.sv
// Bundle between a tap-tick timer and its user: counter taps, arming request
// with target, and the tick / status / count results.
interface tap_tick_timer_if #(
    parameter int CNT_W   = 2,
    parameter int SEL_W   = 1,
    parameter int TICKS_W = 8
);
    logic [CNT_W-1:0]   q_in;
    logic [SEL_W-1:0]   tap_sel;
    logic               start;
    logic [TICKS_W-1:0] target;
    logic               tick;
    logic               busy;
    logic               done;
    logic [TICKS_W-1:0] tick_count;

    modport master (
        output q_in, tap_sel, start, target,
        input  tick, busy, done, tick_count
    );

    modport slave (
        input  q_in, tap_sel, start, target,
        output tick, busy, done, tick_count
    );
endinterface

// File: rtl/tap_tick_timer.sv
// Turns rising edges of one selected counter tap into clk-domain ticks and
// counts them up to a programmable target, flagging completion.
module tap_tick_timer #(
    parameter int CNT_W   = 2,
    parameter int SEL_W   = 1,
    parameter int TICKS_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    tap_tick_timer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [TICKS_W-1:0] CNT_ZERO = {TICKS_W{1'b0}};
    localparam logic [TICKS_W-1:0] CNT_ONE  = {{(TICKS_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [CNT_W-1:0]   q_prev_r;
    logic               tick_r;
    logic               busy_r;
    logic               done_r;
    logic [TICKS_W-1:0] target_r;
    logic [TICKS_W-1:0] count_r;
    logic               tap_ok_s;
    logic               edge_s;

    // Rising-edge detect on the selected tap; out-of-range taps never fire.
    always_comb begin
        tap_ok_s = (32'(bus.tap_sel) < 32'(CNT_W));
        edge_s   = 1'b0;
        if (tap_ok_s) begin
            edge_s = bus.q_in[bus.tap_sel] & ~q_prev_r[bus.tap_sel];
        end else begin
            edge_s = 1'b0;
        end
    end

    // Tap history and tick strobe; the whole vector is kept so a tap_sel
    // change compares the new bit against its own previous sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_prev_r <= {CNT_W{1'b0}};
            tick_r   <= 1'b0;
        end else begin
            q_prev_r <= bus.q_in;
            tick_r   <= edge_s;
        end
    end

    // Timer FSM; counts the registered tick so a tick coinciding with the
    // accepted start is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            target_r <= CNT_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        target_r <= bus.target;
                        count_r  <= CNT_ZERO;
                        if (bus.target == CNT_ZERO) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (tick_r) begin
                        count_r <= count_r + CNT_ONE;
                        if (count_r == (target_r - CNT_ONE)) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    count_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.tick       = tick_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.tick_count = count_r;

endmodule

// File: tb/tb_tap_tick_timer.sv
// Directed bench for tap_tick_timer with q_in driven as a free-running 2-bit
// up-counter; a small edge-detect model supplies the expected tick stream.
module tb_tap_tick_timer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic exp_tick;
    logic [1:0] mq_prev;

    tap_tick_timer_if #(.CNT_W(2), .SEL_W(1), .TICKS_W(8)) bus ();

    tap_tick_timer #(.CNT_W(2), .SEL_W(1), .TICKS_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: inputs settle before the edge, outputs sampled 1 time unit after.
    task automatic cyc();
        logic [1:0] samp;
        logic       sel;
        logic       rst;
        samp = bus.q_in;
        sel  = bus.tap_sel;
        rst  = reset;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_tick = 1'b0;
            mq_prev  = 2'd0;
        end else begin
            exp_tick = samp[sel] & ~mq_prev[sel];
            mq_prev  = samp;
        end
        bus.q_in = bus.q_in + 2'd1;
    endtask

    task automatic test_reset();
        int guard;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if (bus.tick !== 1'b0) $display("FAIL rst_tick got %0b want 0", bus.tick); else n_pass++;
            n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", bus.busy); else n_pass++;
            n_checks++; if (bus.done !== 1'b0) $display("FAIL rst_done got %0b want 0", bus.done); else n_pass++;
            n_checks++; if (bus.tick_count !== 8'd0) $display("FAIL rst_count got %0d want 0", bus.tick_count); else n_pass++;
        end
        guard = 0;
        while (bus.q_in != 2'd3 && guard < 4) begin
            cyc();
            guard++;
        end
        n_checks++; if (bus.q_in !== 2'd3) $display("FAIL rst_align got %0d want 3", bus.q_in); else n_pass++;
        // q_in = 3 with tap 1 already high: first edge after reset ticks because q_prev is 0
        reset = 1'b0;
        bus.tap_sel = 1'b1;
        cyc();
        n_checks++; if (bus.tick !== 1'b1) $display("FAIL first_tick got %0b want 1", bus.tick); else n_pass++;
        cyc();
        n_checks++; if (bus.tick !== 1'b0) $display("FAIL first_tick_after got %0b want 0", bus.tick); else n_pass++;
    endtask

    task automatic test_tick_pattern();
        int ticks;
        bus.tap_sel = 1'b0;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_checks++; if (bus.tick !== exp_tick) $display("FAIL tick_sel0 cyc %0d got %0b want %0b", i, bus.tick, exp_tick); else n_pass++;
            if (bus.tick === 1'b1) ticks++;
        end
        n_checks++; if (ticks != 4) $display("FAIL tick_sel0_rate got %0d want 4", ticks); else n_pass++;
        bus.tap_sel = 1'b1;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            n_checks++; if (bus.tick !== exp_tick) $display("FAIL tick_sel1 cyc %0d got %0b want %0b", i, bus.tick, exp_tick); else n_pass++;
            if (bus.tick === 1'b1) ticks++;
        end
        n_checks++; if (ticks != 2) $display("FAIL tick_sel1_rate got %0d want 2", ticks); else n_pass++;
    endtask

    // Arms the timer with tgt and steps until done (or until count reaches stop_at);
    // if mid_at >= 0, a start with target 5 is pulsed once the count reaches mid_at.
    task automatic run_timer(input logic [7:0] tgt, input int stop_at, input int mid_at, input string nm);
        int   exp_cnt;
        int   n;
        bit   fin;
        bit   pulsed;
        logic t;
        logic m_busy;
        exp_cnt = 0;
        n       = 0;
        fin     = 1'b0;
        pulsed  = 1'b0;
        bus.target = tgt;
        bus.start  = 1'b1;
        cyc();
        bus.start  = 1'b0;
        bus.target = 8'd0;
        m_busy = (tgt != 8'd0);
        n_checks++; if (bus.busy !== m_busy) $display("FAIL %s_arm_busy got %0b want %0b", nm, bus.busy, m_busy); else n_pass++;
        n_checks++; if (bus.done !== !m_busy) $display("FAIL %s_arm_done got %0b want %0b", nm, bus.done, !m_busy); else n_pass++;
        n_checks++; if (bus.tick_count !== 8'd0) $display("FAIL %s_arm_count got %0d want 0", nm, bus.tick_count); else n_pass++;
        if (tgt == 8'd0) fin = 1'b1;
        while (!fin && n < 60) begin
            t = exp_tick;
            if (mid_at >= 0 && !pulsed && exp_cnt == mid_at) begin
                bus.start  = 1'b1;
                bus.target = 8'd5;
                pulsed     = 1'b1;
            end
            cyc();
            n++;
            bus.start  = 1'b0;
            bus.target = 8'd0;
            if (t && m_busy) exp_cnt++;
            m_busy = (exp_cnt != int'(tgt));
            n_checks++; if (bus.tick_count !== 8'(exp_cnt)) $display("FAIL %s_count cyc %0d got %0d want %0d", nm, n, bus.tick_count, exp_cnt); else n_pass++;
            n_checks++; if (bus.busy !== m_busy) $display("FAIL %s_busy cyc %0d got %0b want %0b", nm, n, bus.busy, m_busy); else n_pass++;
            n_checks++; if (bus.done !== !m_busy) $display("FAIL %s_done cyc %0d got %0b want %0b", nm, n, bus.done, !m_busy); else n_pass++;
            if (!m_busy || exp_cnt == stop_at) fin = 1'b1;
        end
        n_checks++; if (!fin) $display("FAIL %s_timeout got %0d cycles want completion", nm, n); else n_pass++;
        if (stop_at < 0 && tgt != 8'd0) begin
            n_checks++;
            if (n < 4 * int'(tgt) - 3 || n > 4 * int'(tgt))
                $display("FAIL %s_latency got %0d want %0d..%0d", nm, n, 4 * int'(tgt) - 3, 4 * int'(tgt));
            else n_pass++;
            cyc();
            n_checks++; if (bus.tick_count !== tgt) $display("FAIL %s_hold_count got %0d want %0d", nm, bus.tick_count, tgt); else n_pass++;
            n_checks++; if (bus.done !== 1'b1) $display("FAIL %s_hold_done got %0b want 1", nm, bus.done); else n_pass++;
        end
    endtask

    task automatic test_count();
        bus.tap_sel = 1'b1;
        run_timer(8'd3, -1, -1, "t3");
    endtask

    task automatic test_zero_target();
        run_timer(8'd0, -1, -1, "t4");
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++; if (bus.busy !== 1'b0) $display("FAIL t4_busy cyc %0d got %0b want 0", i, bus.busy); else n_pass++;
            n_checks++; if (bus.done !== 1'b1 || bus.tick_count !== 8'd0)
                $display("FAIL t4_hold cyc %0d got done=%0b count=%0d want done=1 count=0", i, bus.done, bus.tick_count);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        run_timer(8'd4, -1, 1, "t5a");
        run_timer(8'd2, -1, -1, "t5b");
    endtask

    task automatic test_reset_mid_run();
        run_timer(8'd3, 1, -1, "t6a");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_checks++; if (bus.tick !== 1'b0) $display("FAIL t6_tick got %0b want 0", bus.tick); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL t6_busy got %0b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL t6_done got %0b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.tick_count !== 8'd0) $display("FAIL t6_count got %0d want 0", bus.tick_count); else n_pass++;
        cyc();
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tick_count !== 8'd0)
            $display("FAIL t6_idle got busy=%0b done=%0b count=%0d want 0/0/0", bus.busy, bus.done, bus.tick_count);
        else n_pass++;
        run_timer(8'd3, -1, -1, "t6b");
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        exp_tick    = 1'b0;
        mq_prev     = 2'd0;
        reset       = 1'b1;
        bus.q_in    = 2'd0;
        bus.tap_sel = 1'b1;
        bus.start   = 1'b0;
        bus.target  = 8'd0;
        test_reset();
        test_tick_pattern();
        test_count();
        test_zero_target();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
